led_matrix4x4_drv: RTL and testbench
====================================

Name: led_matrix4x4_drv

Overview:
- Time-multiplexed driver for the 4x4 mole LED matrix; the output-side counterpart of the 4x4 keypad scanner.
- Game logic writes a 16-bit lit pattern plus a 16-bit blink mask through a single-pulse load.
- The block double-buffers the frame and swaps only at frame boundaries, so there is no tearing.
- It drives one active-low row select at a time and the active-high column data, with anti-ghost blanking at each row start.

Parameters:
- ROW_CYCLES, 250000: clocks per row slot (5 ms at 50 MHz; 4 rows give a 20 ms frame).
- BLANK_CYCLES, 1000: clocks at the start of each row slot during which columns are forced off; legal range 1..ROW_CYCLES-1.
- BLINK_FRAMES, 25: frames per blink half-period (0.5 s).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- frame_data  in  16  lit pattern; bit 4*r+c = row r, column c
- blink_mask  in  16  same mapping; 1 = LED blinks when lit
- frame_load  in  1  1-cycle strobe; captures frame_data and blink_mask
- load_pending  out  1  shadow frame captured, not yet displayed
- frame_tick  out  1  1-cycle pulse on the last clock of row 3
- row_sel_n  out  4  row select, active-low, at most one bit low
- col_out  out  4  column drive, active-high

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values:
  - row_sel_n=4'b1111, col_out=0, frame_tick=0, load_pending=0.
  - Internal: cnt=0, row=0, shadow and active pattern/mask=0, blink frame counter=0, blink phase=0.
  - Assertion mid-operation returns everything to these values immediately; any pending frame is discarded.
- Timing generator:
  - cnt counts 0..ROW_CYCLES-1.
  - At cnt==ROW_CYCLES-1, cnt goes to 0 and row increments, wrapping 3->0.
  - frame_end = (cnt==ROW_CYCLES-1 && row==3).
- Outputs are registered, 1-cycle latency from (cnt,row):
  - row_sel_n <= ~(4'b0001 << row).
  - col_out <= 0 when cnt < BLANK_CYCLES; otherwise active_pat[4r+3:4r] & ~(active_blink[4r+3:4r] & {4{blink_phase}}).
  - The first edge after reset release gives row_sel_n=4'b1110 and col_out=0.
- frame_tick <= frame_end (registered, asserted coincident with row 3's final output cycle +1).
- Load and swap:
  - frame_load captures frame_data and blink_mask into shadow and sets load_pending.
  - A further load while pending overwrites the shadow; last one wins.
  - At frame_end with load_pending=1: active <= shadow, load_pending <= 0.
  - Simultaneous frame_load and frame_end: active takes the incoming frame_data/blink_mask directly and load_pending ends at 0.
  - The active pattern never changes at any other time.
- Blink:
  - At each frame_end, the frame counter increments.
  - At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - A phase change takes effect from row 0 of the next frame.
- Width rules:
  - cnt width = $clog2(ROW_CYCLES); blink counter width = $clog2(BLINK_FRAMES)+1.
  - No overflow is possible.
- Row-select invariant: never more than one row_sel_n bit low in any cycle.

Decomposition:
- Shared package led_matrix_pkg holds:
  - ROWS=4 and COLS=4.
  - The function onehot_n(row) returning the active-low row select.
  - The bit-index convention 4*r+c, shared with the keypad scanner's row ordering.
- Natural sub-module: led_scan_timer (cnt, row, frame_end, blank), parameterised by ROW_CYCLES and BLANK_CYCLES.
- The top holds the buffers, the blink logic and the output registers.

Test Plan (bench uses ROW_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2):
1. Reset released, no load -> row_sel_n cycles 1110,1101,1011,0111, 8 clocks each; col_out=0 throughout; frame_tick pulses every 32 clocks.
2. frame_load with frame_data=16'hA5C3, blink_mask=0, mid row 1 -> load_pending=1 until frame_end, then 0. From the next row 0: col_out=0 for 2 clocks then 4'h3; row 1 = 4'hC; row 2 = 4'h5; row 3 = 4'hA.
3. Two loads, 16'h000F then 16'hF000, within one frame -> only 16'hF000 is displayed (row 3 = 4'hF, others 0); 16'h000F never appears.
4. frame_load asserted on the frame_end cycle with 16'h00F0 -> load_pending stays 0; the next frame shows row 1 = 4'hF.
5. frame_data=16'hFFFF, blink_mask=16'h0001 -> row 0 col_out alternates 4'hF / 4'hE every 2 frames; other rows stay 4'hF.
6. rst_n pulsed low mid row 2 with a load pending -> outputs go to 1111/0 immediately (asynchronously); after release row 0 restarts and col_out=0 (buffers cleared).

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the 4x4 mole LED matrix driver.
// Row ordering matches the keypad scanner: flat bit 4*r+c is row r, column c.
package led_matrix_pkg;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ROW_W = $clog2(ROWS);

  // frame[r][c] lands on flat bit 4*r+c, so a 16-bit word casts straight in.
  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  typedef struct packed {
    frame_t pat;
    frame_t blink;
  } frame_buf_t;

  function automatic logic [ROWS-1:0] onehot_n(input logic [ROW_W-1:0] row);
    return ~({{(ROWS-1){1'b0}}, 1'b1} << row);
  endfunction
endpackage

// File: rtl/led_matrix4x4_drv_if.sv
// Game-logic / panel-side signal bundle of the LED matrix driver.
interface led_matrix4x4_drv_if;
  import led_matrix_pkg::*;

  logic [ROWS*COLS-1:0] frame_data;
  logic [ROWS*COLS-1:0] blink_mask;
  logic                 frame_load;
  logic                 load_pending;
  logic                 frame_tick;
  logic [ROWS-1:0]      row_sel_n;
  logic [COLS-1:0]      col_out;

  modport master (
    output frame_data, blink_mask, frame_load,
    input  load_pending, frame_tick, row_sel_n, col_out
  );

  modport slave (
    input  frame_data, blink_mask, frame_load,
    output load_pending, frame_tick, row_sel_n, col_out
  );
endinterface

// File: rtl/led_scan_timer.sv
// Row-slot timing: cycle counter within a row slot, current row, frame end
// and the anti-ghost blanking window at the start of every slot.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int ROW_CYCLES   = 250000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [ROW_W-1:0] row_o,
  output logic             frame_end_o,
  output logic             blank_o
);
  localparam int CW = $clog2(ROW_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0]    BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    row_d = row_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  assign row_o       = row_q;
  assign frame_end_o = (cnt_q == CNT_LAST) && (row_q == ROW_LAST);
  assign blank_o     = (cnt_q < BLANK_END);
endmodule

// File: rtl/led_matrix4x4_drv.sv
// Time-multiplexed 4x4 LED matrix driver: double-buffered frame swapped only
// at frame end, per-LED blink, one active-low row at a time with blanking.
module led_matrix4x4_drv
  import led_matrix_pkg::*;
#(
  parameter int ROW_CYCLES   = 250000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  led_matrix4x4_drv_if.slave  bus
);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [ROW_W-1:0] row;
  logic             frame_end, blank;

  led_scan_timer #(
    .ROW_CYCLES   (ROW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_o       (row),
    .frame_end_o (frame_end),
    .blank_o     (blank)
  );

  frame_buf_t      incoming;
  frame_buf_t      shadow_q, shadow_d, active_q, active_d;
  logic            pend_q, pend_d, phase_q, phase_d, tick_q;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_q, col_d;

  always_comb begin
    incoming.pat   = bus.frame_data;
    incoming.blink = bus.blink_mask;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pend_d    = pend_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    if (bus.frame_load) begin
      shadow_d = incoming;
      pend_d   = 1'b1;
    end
    if (frame_end) begin
      // A load landing on the boundary goes straight to the display.
      if (bus.frame_load)  active_d = incoming;
      else if (pend_q)     active_d = shadow_q;
      pend_d = 1'b0;
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
    row_sel_d = onehot_n(row);
    col_d     = blank ? '0
              : active_q.pat[row] & ~(active_q.blink[row] & {COLS{phase_q}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pend_q    <= 1'b0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      row_sel_q <= '1;
      col_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      tick_q    <= frame_end;
    end
  end

  assign bus.load_pending = pend_q;
  assign bus.frame_tick   = tick_q;
  assign bus.row_sel_n    = row_sel_q;
  assign bus.col_out      = col_q;
endmodule

// File: tb/tb_led_matrix4x4_drv.sv
// Directed bench for led_matrix4x4_drv: stimulus queues one expected entry per
// displayed row slot; a monitor pops one per slot and checks every cycle.
module tb_led_matrix4x4_drv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_matrix4x4_drv_if bus();

  led_matrix4x4_drv #(
    .ROW_CYCLES   (8),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] rs;
    logic [3:0] col;
    logic       pend;
  } slot_t;

  slot_t q[$];
  int ocyc;
  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] RS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Index of the output cycle currently presented; -1 while in reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ocyc <= -1;
    else        ocyc <= ocyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at oc=%0d: got %h expected %h", name, ocyc, act, exp);
  endtask

  // cols: displayed nibble per row (bits 4r+3:4r); pend bit r: load_pending at row r's last cycle.
  task automatic push_frame(input logic [15:0] cols, input logic [3:0] pend);
    for (int r = 0; r < 4; r++)
      q.push_back('{rs: RS[r], col: cols[4*r +: 4], pend: pend[r]});
  endtask

  task automatic wait_oc(input int n);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (ocyc != n && i < 5000);
    if (ocyc != n) begin
      n_chk++;
      $display("FAIL timeout waiting for oc=%0d, got %0d", n, ocyc);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [15:0] m);
    bus.frame_data = d;
    bus.blink_mask = m;
    bus.frame_load = 1'b1;
    @(negedge clk);
    bus.frame_load = 1'b0;
  endtask

  initial begin : monitor
    slot_t cur;
    bit    have;
    int    k;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || ocyc < 0) begin
        have = 1'b0;
      end else begin
        k = ocyc % 8;
        if (k == 0) begin
          if (q.size() > 0) begin
            cur  = q.pop_front();
            have = 1'b1;
          end else begin
            have = 1'b0;
          end
        end
        if (have) begin
          check("row_sel_n", bus.row_sel_n, cur.rs);
          check("col_out", bus.col_out, (k < 2) ? 4'h0 : cur.col);
          check("frame_tick", {3'b0, bus.frame_tick}, {3'b0, (k == 7 && cur.rs == 4'b0111)});
          if (k == 7) check("load_pending", {3'b0, bus.load_pending}, {3'b0, cur.pend});
        end
      end
    end
  end

  initial begin : stim
    bus.frame_data = '0;
    bus.blink_mask = '0;
    bus.frame_load = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row_sel_n", bus.row_sel_n, 4'b1111);
    check("rst_col_out", bus.col_out, 4'h0);
    check("rst_frame_tick", {3'b0, bus.frame_tick}, 4'h0);
    check("rst_load_pending", {3'b0, bus.load_pending}, 4'h0);

    // Blank frame, then A5C3 loaded mid row 1 and shown from frame 2.
    push_frame(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0110);
    push_frame(16'hA5C3, 4'b0000);
    rst_n = 1'b1;
    wait_oc(43);  load(16'hA5C3, 16'h0000);

    // Two loads in frame 3: last one wins.
    push_frame(16'hA5C3, 4'b0111);
    push_frame(16'hF000, 4'b0000);
    wait_oc(98);  load(16'h000F, 16'h0000);
    wait_oc(108); load(16'hF000, 16'h0000);

    // Load on the frame_end cycle of frame 4: pending never seen.
    push_frame(16'h00F0, 4'b0111);
    wait_oc(158); load(16'h00F0, 16'h0000);

    // Blink on LED 0: phase is 1 in frames 6,7,10 and 0 in frames 8,9.
    push_frame(16'hFFFE, 4'b0000);
    push_frame(16'hFFFE, 4'b0000);
    push_frame(16'hFFFF, 4'b0000);
    push_frame(16'hFFFF, 4'b0000);
    q.push_back('{rs: 4'b1110, col: 4'hE, pend: 1'b1});
    q.push_back('{rs: 4'b1101, col: 4'hF, pend: 1'b1});
    q.push_back('{rs: 4'b1011, col: 4'hF, pend: 1'b1});
    wait_oc(163); load(16'hFFFF, 16'h0001);

    // Pending load in frame 10, then reset mid row 2.
    wait_oc(323); load(16'h1234, 16'h0000);
    wait_oc(340);
    #2 rst_n = 1'b0;
    #1;
    check("async_row_sel_n", bus.row_sel_n, 4'b1111);
    check("async_col_out", bus.col_out, 4'h0);
    check("async_load_pending", {3'b0, bus.load_pending}, 4'h0);
    check("async_frame_tick", {3'b0, bus.frame_tick}, 4'h0);
    push_frame(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_oc(63);
    @(negedge clk);

    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drained: %0d slots left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
